// File: rtl/nv_nvdla_sdp_pipe_pkg.sv
// Shared constants and helpers for the SDP request pipe family.
package nv_nvdla_sdp_pipe_pkg;

  // Default request payload width (SDP DMA request descriptor).
  localparam int SDP_PIPE_DW_DEFAULT = 79;

  // Legal range for the number of pipe registers behind the skid stage.
  localparam int SDP_PIPE_MIN_STAGES = 1;
  localparam int SDP_PIPE_MAX_STAGES = 8;

  // Occupancy counter width: must hold 0..num_stages+1 (stages plus skid entry).
  function automatic int sdp_pipe_cnt_w(input int num_stages);
    return $clog2(num_stages + 2);
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_pipe_stage.sv
// One bubble-collapsing valid/ready pipe register.
// Accepts a new beat whenever it is empty or its own beat is leaving this cycle.
module nv_nvdla_sdp_pipe_stage #(
  parameter int DW = 79
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_pd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_pd
);

  logic          valid_d;
  logic          valid_q;
  logic [DW-1:0] data_d;
  logic [DW-1:0] data_q;
  logic          ready_bc;

  // Next-state: hold while stalled, collapse bubbles, flush clears the valid only.
  always_comb begin
    ready_bc = out_ready | ~valid_q;
    valid_d  = valid_q;
    data_d   = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (ready_bc) begin
      valid_d = in_valid;
    end
    if (ready_bc && in_valid) begin
      data_d = in_pd;
    end
  end

  // Valid flop with async reset.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload flop; deliberately not reset, only meaningful under valid_q.
  always_ff @(posedge nvdla_core_clk) begin
    data_q <= data_d;
  end

  assign out_valid = valid_q;
  assign out_pd    = data_q;

endmodule

// File: rtl/nv_nvdla_sdp_req_pipe_skid_n.sv
// SDP DMA request pipe: a registered-ready skid entry in front of NUM_STAGES
// bubble-collapsing pipe registers, with occupancy count, idle flag and flush.
// in_ready comes straight from a flop so the upstream generator never sees the
// downstream ready path; the skid entry absorbs the one beat accepted while
// that registered ready is still catching up.
module nv_nvdla_sdp_req_pipe_skid_n
  import nv_nvdla_sdp_pipe_pkg::*;
#(
  parameter  int DW         = SDP_PIPE_DW_DEFAULT,
  parameter  int NUM_STAGES = 1,
  localparam int CW         = sdp_pipe_cnt_w(NUM_STAGES)
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_pd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_pd,
  input  logic          flush,
  output logic [CW-1:0] pipe_cnt,
  output logic          pipe_idle
);

  if (NUM_STAGES < SDP_PIPE_MIN_STAGES || NUM_STAGES > SDP_PIPE_MAX_STAGES) begin : g_bad_num_stages
    $error("nv_nvdla_sdp_req_pipe_skid_n: NUM_STAGES must be in 1..8");
  end

  localparam logic [CW-1:0] CNT_MAX = CW'(NUM_STAGES + 1);

  logic                  in_ready_d;
  logic                  in_ready_q;
  logic                  skid_valid_d;
  logic                  skid_valid_q;
  logic [DW-1:0]         skid_data_d;
  logic [DW-1:0]         skid_data_q;
  logic                  skid_catch;
  logic                  s0_valid;
  logic [DW-1:0]         s0_pd;
  logic [NUM_STAGES-1:0] stg_valid;
  logic [DW-1:0]         stg_pd [NUM_STAGES];
  logic [NUM_STAGES-1:0] ready_bc;
  logic                  in_acc;
  logic                  out_acc;
  logic [CW-1:0]         cnt_d;
  logic [CW-1:0]         cnt_q;
  logic                  idle_d;
  logic                  idle_q;

  // Backward ready chain: stage k can take a beat if it is empty or everything ahead moves.
  always_comb begin
    logic rdy;
    ready_bc = '0;
    rdy      = out_ready;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      rdy         = rdy | ~stg_valid[k];
      ready_bc[k] = rdy;
    end
  end

  // Skid control: catch the beat stage 0 cannot take, release it once stage 0 frees up.
  always_comb begin
    skid_catch   = in_valid & in_ready_q & ~ready_bc[0];
    in_ready_d   = in_ready_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      in_ready_d   = 1'b1;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      in_ready_d   = ready_bc[0];
      skid_valid_d = ~ready_bc[0];
    end else if (skid_catch) begin
      in_ready_d   = 1'b0;
      skid_valid_d = 1'b1;
    end
    if (skid_catch) begin
      skid_data_d = in_pd;
    end
  end

  // Stage 0 sees the live input while ready is high, otherwise the parked skid beat.
  always_comb begin
    s0_valid = in_ready_q ? in_valid : skid_valid_q;
    s0_pd    = in_ready_q ? in_pd    : skid_data_q;
  end

  // Occupancy: +1 per accepted input, -1 per delivered output, flush empties.
  always_comb begin
    in_acc  = in_valid & in_ready_q;
    out_acc = stg_valid[NUM_STAGES-1] & out_ready;
    cnt_d   = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (in_acc && !out_acc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!in_acc && out_acc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
    idle_d = (cnt_d == '0);
  end

  // Control flops with async reset.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      in_ready_q   <= 1'b1;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
      idle_q       <= 1'b1;
    end else begin
      in_ready_q   <= in_ready_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
      idle_q       <= idle_d;
    end
  end

  // Skid payload flop; not reset, only meaningful under skid_valid_q.
  always_ff @(posedge nvdla_core_clk) begin
    skid_data_q <= skid_data_d;
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic          st_in_valid;
    logic [DW-1:0] st_in_pd;
    logic          st_out_ready;

    if (k == 0) begin : g_head
      assign st_in_valid = s0_valid;
      assign st_in_pd    = s0_pd;
    end else begin : g_link
      assign st_in_valid = stg_valid[k-1];
      assign st_in_pd    = stg_pd[k-1];
    end

    if (k == NUM_STAGES - 1) begin : g_tail
      assign st_out_ready = out_ready;
    end else begin : g_mid
      assign st_out_ready = ready_bc[k+1];
    end

    nv_nvdla_sdp_pipe_stage #(
      .DW (DW)
    ) u_stage (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .flush           (flush),
      .in_valid        (st_in_valid),
      .in_pd           (st_in_pd),
      .out_valid       (stg_valid[k]),
      .out_ready       (st_out_ready),
      .out_pd          (stg_pd[k])
    );
  end

  assign in_ready  = in_ready_q;
  assign out_valid = stg_valid[NUM_STAGES-1];
  assign out_pd    = stg_pd[NUM_STAGES-1];
  assign pipe_cnt  = cnt_q;
  assign pipe_idle = idle_q;

endmodule

// File: tb/tb_nv_nvdla_sdp_req_pipe_skid_n.sv
// Bench for the SDP request pipe: four instances (DW=79/N=2 for directed cases,
// DW=8 with N=1,4,8 for random traffic) checked every cycle against a FIFO model.
// Model rules: in order delivery; the oldest held beat shows on the output once
// NUM_STAGES cycles have passed since it was accepted; in_ready is low exactly
// when NUM_STAGES+1 beats are held; flush empties; reset empties.
module tb_nv_nvdla_sdp_req_pipe_skid_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv  [4];
  logic        orr [4];
  logic        fl  [4];
  logic [78:0] ipd [4];
  logic        ir  [4];
  logic        ov  [4];
  logic        idl [4];
  logic [78:0] opd [4];
  logic [3:0]  cnt [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic int ns_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      2:       return 4;
      default: return 8;
    endcase
  endfunction

  task automatic chk(input string nm, input int inst, input logic [78:0] act, input logic [78:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t actual=%0h required=%0h", nm, inst, $time, act, exp);
    end
  endtask

  // ---------------- DUT instances ----------------
  logic [78:0] opd0;
  logic [1:0]  cnt0;
  nv_nvdla_sdp_req_pipe_skid_n #(.DW(79), .NUM_STAGES(2)) u_dut0 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_pd(ipd[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_pd(opd0),
    .flush(fl[0]), .pipe_cnt(cnt0), .pipe_idle(idl[0]));
  assign opd[0] = opd0;
  assign cnt[0] = {2'b00, cnt0};

  logic [7:0] opd1;
  logic [1:0] cnt1;
  nv_nvdla_sdp_req_pipe_skid_n #(.DW(8), .NUM_STAGES(1)) u_dut1 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_pd(ipd[1][7:0]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_pd(opd1),
    .flush(fl[1]), .pipe_cnt(cnt1), .pipe_idle(idl[1]));
  assign opd[1] = {71'd0, opd1};
  assign cnt[1] = {2'b00, cnt1};

  logic [7:0] opd2;
  logic [2:0] cnt2;
  nv_nvdla_sdp_req_pipe_skid_n #(.DW(8), .NUM_STAGES(4)) u_dut2 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_pd(ipd[2][7:0]),
    .out_valid(ov[2]), .out_ready(orr[2]), .out_pd(opd2),
    .flush(fl[2]), .pipe_cnt(cnt2), .pipe_idle(idl[2]));
  assign opd[2] = {71'd0, opd2};
  assign cnt[2] = {1'b0, cnt2};

  logic [7:0] opd3;
  logic [3:0] cnt3;
  nv_nvdla_sdp_req_pipe_skid_n #(.DW(8), .NUM_STAGES(8)) u_dut3 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
    .in_valid(iv[3]), .in_ready(ir[3]), .in_pd(ipd[3][7:0]),
    .out_valid(ov[3]), .out_ready(orr[3]), .out_pd(opd3),
    .flush(fl[3]), .pipe_cnt(cnt3), .pipe_idle(idl[3]));
  assign opd[3] = {71'd0, opd3};
  assign cnt[3] = cnt3;

  // ---------------- model + per-cycle compare ----------------
  int          cyc_n = 0;
  logic [78:0] m_pd   [4][16];
  int          m_t    [4][16];
  int          m_head [4] = '{0, 0, 0, 0};
  int          m_size [4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    logic        e_ov;
    logic        e_ir;
    logic [78:0] mask;
    int          nsi;
    int          idx;
    for (int i = 0; i < 4; i++) begin
      nsi  = ns_of(i);
      mask = (i == 0) ? {79{1'b1}} : 79'hFF;
      if (!rst_n) begin
        m_size[i] = 0;
        m_head[i] = 0;
      end
      e_ov = (m_size[i] > 0) && ((cyc_n - m_t[i][m_head[i]]) >= nsi);
      e_ir = (m_size[i] < nsi + 1);
      chk("out_valid", i, {78'd0, ov[i]}, {78'd0, e_ov});
      chk("in_ready", i, {78'd0, ir[i]}, {78'd0, e_ir});
      chk("pipe_cnt", i, {75'd0, cnt[i]}, 79'(m_size[i]));
      chk("pipe_idle", i, {78'd0, idl[i]}, {78'd0, (m_size[i] == 0)});
      if (e_ov) chk("out_pd", i, opd[i], m_pd[i][m_head[i]]);
      if (rst_n) begin
        if (fl[i]) begin
          m_size[i] = 0;
          m_head[i] = 0;
        end else begin
          if (e_ov && orr[i]) begin
            m_head[i] = (m_head[i] + 1) % 16;
            m_size[i] = m_size[i] - 1;
          end
          if (iv[i] && e_ir) begin
            idx            = (m_head[i] + m_size[i]) % 16;
            m_pd[i][idx]   = ipd[i] & mask;
            m_t[i][idx]    = cyc_n;
            m_size[i]      = m_size[i] + 1;
          end
        end
      end
    end
    cyc_n++;
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int prob_v;
    int prob_r;
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0; orr[i] = 1'b0; fl[i] = 1'b0; ipd[i] = '0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Reset release, idle pipe
    chk("t1_in_ready", 0, {78'd0, ir[0]}, 79'd1);
    chk("t1_out_valid", 0, {78'd0, ov[0]}, 79'd0);
    chk("t1_cnt", 0, {75'd0, cnt[0]}, 79'd0);
    chk("t1_idle", 0, {78'd0, idl[0]}, 79'd1);

    // 16-beat stream, no backpressure: 2-cycle latency, 1 beat/cycle, in order
    for (int c = 0; c < 19; c++) begin
      @(posedge clk); #1;
      orr[0] = 1'b1; iv[0] = (c < 16); ipd[0] = 79'(c);
      @(negedge clk);
      if (c < 2) chk("t2_latency", 0, {78'd0, ov[0]}, 79'd0);
      if (c >= 2 && c < 18) begin
        chk("t2_ov", 0, {78'd0, ov[0]}, 79'd1);
        chk("t2_pd", 0, opd[0], 79'(c - 2));
      end
      if (c == 18) chk("t2_drain_cnt", 0, {75'd0, cnt[0]}, 79'd0);
    end

    // Full pipe under backpressure: exactly 3 beats held, then drain in order
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      orr[0] = 1'b0; iv[0] = 1'b1; ipd[0] = 79'(100 + c);
      @(negedge clk);
    end
    chk("t3_cnt_full", 0, {75'd0, cnt[0]}, 79'd3);
    chk("t3_in_ready", 0, {78'd0, ir[0]}, 79'd0);
    chk("t3_head_pd", 0, opd[0], 79'd100);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      orr[0] = 1'b1; iv[0] = 1'b0;
      @(negedge clk);
      if (c < 3) chk("t3_drain_pd", 0, opd[0], 79'(100 + c));
      if (c == 3) begin
        chk("t3_empty_ov", 0, {78'd0, ov[0]}, 79'd0);
        chk("t3_empty_cnt", 0, {75'd0, cnt[0]}, 79'd0);
      end
    end

    // Flush with a full pipe: head delivered, everything else gone
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      orr[0] = 1'b0; iv[0] = 1'b1; ipd[0] = 79'(200 + c);
      @(negedge clk);
    end
    @(posedge clk); #1;
    fl[0] = 1'b1; orr[0] = 1'b1; iv[0] = 1'b1; ipd[0] = 79'h77;
    @(negedge clk);
    chk("t5_head_ov", 0, {78'd0, ov[0]}, 79'd1);
    chk("t5_head_pd", 0, opd[0], 79'd200);
    @(posedge clk); #1;
    fl[0] = 1'b0; iv[0] = 1'b0;
    @(negedge clk);
    chk("t5_cnt", 0, {75'd0, cnt[0]}, 79'd0);
    chk("t5_ov", 0, {78'd0, ov[0]}, 79'd0);
    chk("t5_in_ready", 0, {78'd0, ir[0]}, 79'd1);

    // Flush while in_ready is high: the beat accepted in the flush cycle is dropped
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      orr[0] = 1'b0; iv[0] = 1'b1; ipd[0] = 79'(210 + c);
      @(negedge clk);
    end
    @(posedge clk); #1;
    fl[0] = 1'b1; iv[0] = 1'b1; ipd[0] = 79'h55;
    @(negedge clk);
    @(posedge clk); #1;
    fl[0] = 1'b0; iv[0] = 1'b0; orr[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5b_dropped_ov", 0, {78'd0, ov[0]}, 79'd0);
    chk("t5b_dropped_cnt", 0, {75'd0, cnt[0]}, 79'd0);

    // Async reset with a full pipe, then a fresh beat
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      orr[0] = 1'b0; iv[0] = 1'b1; ipd[0] = 79'(300 + c);
      @(negedge clk);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ov", 0, {78'd0, ov[0]}, 79'd0);
    chk("t6_rst_in_ready", 0, {78'd0, ir[0]}, 79'd1);
    chk("t6_rst_cnt", 0, {75'd0, cnt[0]}, 79'd0);
    chk("t6_rst_idle", 0, {78'd0, idl[0]}, 79'd1);
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; orr[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b1; ipd[0] = 79'hA5;
    @(negedge clk);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(negedge clk);
    chk("t6_new_latency", 0, {78'd0, ov[0]}, 79'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_new_ov", 0, {78'd0, ov[0]}, 79'd1);
    chk("t6_new_pd", 0, opd[0], 79'hA5);

    // Random valid/ready/flush traffic on the DW=8 instances
    prob_v = 90; prob_r = 90;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        case ((c / 500) % 4)
          0: begin prob_v = 90; prob_r = 90; end
          1: begin prob_v = 90; prob_r = 20; end
          2: begin prob_v = 30; prob_r = 80; end
          default: begin prob_v = 60; prob_r = 50; end
        endcase
      end
      @(posedge clk); #1;
      iv[0] = 1'b0; orr[0] = 1'b1; fl[0] = 1'b0;
      for (int i = 1; i < 4; i++) begin
        iv[i]  = ($urandom_range(0, 99) < prob_v);
        orr[i] = ($urandom_range(0, 99) < prob_r);
        fl[i]  = ($urandom_range(0, 299) == 0);
        ipd[i] = 79'($urandom_range(0, 255));
      end
    end
    @(posedge clk); #1;
    for (int i = 1; i < 4; i++) begin
      iv[i] = 1'b0; orr[i] = 1'b1; fl[i] = 1'b0;
    end
    repeat (12) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("final_empty_cnt", i, {75'd0, cnt[i]}, 79'd0);
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
